// File: rtl/oled_multi_streamer.sv
// rtl/oled_multi_streamer.sv - multi-panel SSD1306 refresh engine sharing one framebuffer read port
// Each channel runs its own window-setup + burst FSM; a round-robin arbiter feeds per-channel 2-entry prefetch FIFOs.
module oled_multi_streamer #(
  parameter int         CH_NUM    = 4,
  parameter int         PAGES     = 8,
  parameter int         COLS      = 128,
  parameter logic [7:0] CMD_ADDR  = 8'h00,
  parameter logic [7:0] DATA_ADDR = 8'h40,
  localparam int        FRAME     = PAGES * COLS,
  localparam int        FB_AW     = (CH_NUM * FRAME > 1) ? $clog2(CH_NUM * FRAME) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                auto_refresh,
  input  logic [CH_NUM-1:0]   refresh_req,
  output logic [FB_AW-1:0]    fb_addr,
  input  logic [7:0]          fb_data,
  output logic [CH_NUM-1:0]   send_en,
  output logic [CH_NUM*8-1:0] send_addr,
  output logic [CH_NUM*8-1:0] send_data,
  input  logic [CH_NUM-1:0]   send_busy,
  input  logic [CH_NUM-1:0]   brust_ready,
  output logic [CH_NUM-1:0]   brust_vaild,
  output logic [CH_NUM-1:0]   busy,
  output logic [CH_NUM-1:0]   frame_done
);
  localparam int IW = $clog2(FRAME + 1);
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME - 1);
  localparam logic [IW-1:0] FRAME_IDX = IW'(FRAME);
  localparam logic [1:0]    START_LVL = (FRAME == 1) ? 2'd1 : 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_CMD_WAIT, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t            state     [CH_NUM];
  logic [2:0]        cmd_idx   [CH_NUM];
  logic [7:0]        cmd_byte  [CH_NUM];
  logic [7:0]        addr_q    [CH_NUM];
  logic [IW-1:0]     fetch_idx [CH_NUM];
  logic [IW-1:0]     popped    [CH_NUM];
  logic [1:0]        fcnt      [CH_NUM];
  logic [7:0]        fifo_mem  [CH_NUM][2];
  logic [CH_NUM-1:0] rd_ptr, wr_ptr, wait_fall, pending, en_q, busy_q, done_q;
  logic [CH_NUM-1:0] elig, wr_en, pop_en;
  logic [CW-1:0]     rr_ptr, rd_ch, gnt_ch;
  logic              rd_vld, gnt_valid;

  function automatic logic [7:0] cmd_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h21;
      3'd2:    return 8'(COLS - 1);
      3'd3:    return 8'h22;
      3'd5:    return 8'(PAGES - 1);
      default: return 8'h00;
    endcase
  endfunction

  // A read landing this cycle still counts against the FIFO limit, so occupancy never exceeds 2.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      wr_en[c]  = rd_vld && (rd_ch == CW'(c));
      pop_en[c] = (state[c] == S_STREAM) && brust_ready[c] && (fcnt[c] != 2'd0);
      elig[c]   = busy_q[c] && (fetch_idx[c] != FRAME_IDX) &&
                  (({1'b0, fcnt[c]} + {2'b00, wr_en[c]}) < 3'd2);
    end
    for (int i = 0; i < CH_NUM; i++) begin
      if (!gnt_valid && elig[(int'(rr_ptr) + i) % CH_NUM]) begin
        gnt_valid = 1'b1;
        gnt_ch    = CW'((int'(rr_ptr) + i) % CH_NUM);
      end
    end
    fb_addr = gnt_valid ? FB_AW'(int'(gnt_ch) * FRAME + int'(fetch_idx[gnt_ch])) : '0;
  end

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      send_data[c*8 +: 8] = (state[c] == S_STREAM) ? fifo_mem[c][rd_ptr[c]] : cmd_byte[c];
      send_addr[c*8 +: 8] = addr_q[c];
      brust_vaild[c]      = (state[c] == S_STREAM) && (popped[c] != LAST_IDX);
    end
  end

  assign send_en    = en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      rd_vld <= 1'b0;
      rd_ch  <= '0;
      rd_ptr <= '0; wr_ptr <= '0; wait_fall <= '0; pending <= '0;
      en_q   <= '0; busy_q <= '0; done_q <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        state[c]       <= S_IDLE;
        cmd_idx[c]     <= '0;
        cmd_byte[c]    <= '0;
        addr_q[c]      <= '0;
        fetch_idx[c]   <= '0;
        popped[c]      <= '0;
        fcnt[c]        <= '0;
        fifo_mem[c][0] <= '0;
        fifo_mem[c][1] <= '0;
      end
    end else begin
      rd_vld <= gnt_valid;
      rd_ch  <= gnt_ch;
      if (gnt_valid) rr_ptr <= (int'(gnt_ch) == CH_NUM - 1) ? '0 : gnt_ch + 1'b1;
      en_q   <= '0;
      done_q <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        if (gnt_valid && gnt_ch == CW'(c)) fetch_idx[c] <= fetch_idx[c] + 1'b1;
        if (wr_en[c]) begin
          fifo_mem[c][wr_ptr[c]] <= fb_data;
          wr_ptr[c] <= ~wr_ptr[c];
        end
        if (pop_en[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
          popped[c] <= popped[c] + 1'b1;
        end
        fcnt[c] <= fcnt[c] + {1'b0, wr_en[c]} - {1'b0, pop_en[c]};
        if (refresh_req[c] && state[c] != S_IDLE) pending[c] <= 1'b1;
        case (state[c])
          S_IDLE: if (refresh_req[c] || pending[c] || auto_refresh) begin
            state[c]     <= S_CMD;
            busy_q[c]    <= 1'b1;
            pending[c]   <= 1'b0;
            cmd_idx[c]   <= '0;
            fetch_idx[c] <= '0;
            popped[c]    <= '0;
            fcnt[c]      <= '0;
            rd_ptr[c]    <= 1'b0;
            wr_ptr[c]    <= 1'b0;
          end
          S_CMD: if (!send_busy[c]) begin
            en_q[c]      <= 1'b1;
            addr_q[c]    <= CMD_ADDR;
            cmd_byte[c]  <= cmd_rom(cmd_idx[c]);
            wait_fall[c] <= 1'b0;
            state[c]     <= S_CMD_WAIT;
          end
          S_CMD_WAIT: begin
            if (!wait_fall[c]) begin
              if (send_busy[c]) wait_fall[c] <= 1'b1;
            end else if (!send_busy[c]) begin
              if (cmd_idx[c] == 3'd5) state[c] <= S_LOAD;
              else begin
                cmd_idx[c] <= cmd_idx[c] + 3'd1;
                state[c]   <= S_CMD;
              end
            end
          end
          S_LOAD: if (fcnt[c] >= START_LVL && !send_busy[c]) begin
            en_q[c]   <= 1'b1;
            addr_q[c] <= DATA_ADDR;
            state[c]  <= S_STREAM;
          end
          S_STREAM: if (pop_en[c] && popped[c] == LAST_IDX) state[c] <= S_DONE;
          S_DONE: if (!send_busy[c]) begin
            done_q[c] <= 1'b1;
            busy_q[c] <= 1'b0;
            state[c]  <= S_IDLE;
          end
          default: state[c] <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oled_multi_streamer.sv
// tb/tb_oled_multi_streamer.sv - randomized bench with per-channel I2C master models and a frame-sequence reference
module tb_oled_multi_streamer;
  localparam int CH = 4, PG = 2, CL = 24, FR = PG * CL;
  localparam int AW = $clog2(CH * FR);

  logic          clk = 1'b0, rst_n = 1'b0, auto_refresh = 1'b0;
  logic [CH-1:0] refresh_req = '0, send_busy = '0, brust_ready = '0;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data = '0;
  logic [CH-1:0] send_en, brust_vaild, busy, frame_done;
  logic [CH*8-1:0] send_addr, send_data;

  logic [7:0] fb_mem [CH*FR];
  int checks = 0, failures = 0;
  int pos[CH], frames_seen[CH], done_cnt[CH], exp_frames[CH], mst[CH], dly[CH];
  int rr_exp[9] = '{0, 48, 96, 144, 1, 49, 97, 145, 0};

  oled_multi_streamer #(.CH_NUM(CH), .PAGES(PG), .COLS(CL)) dut (
    .clk(clk), .rst_n(rst_n), .auto_refresh(auto_refresh), .refresh_req(refresh_req),
    .fb_addr(fb_addr), .fb_data(fb_data), .send_en(send_en), .send_addr(send_addr),
    .send_data(send_data), .send_busy(send_busy), .brust_ready(brust_ready),
    .brust_vaild(brust_vaild), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame = six window commands, then FRAME data bytes; returns {addr, data, more}.
  function automatic logic [16:0] model_byte(input int c, input int p);
    logic [7:0] d;
    if (p < 6) begin
      case (p)
        0: d = 8'h21;
        2: d = 8'h17;
        3: d = 8'h22;
        5: d = 8'h01;
        default: d = 8'h00;
      endcase
      return {8'h00, d, 1'b0};
    end
    return {8'h40, fb_mem[c*FR + p - 6], (p != FR + 5)};
  endfunction

  task automatic consume(input int c);
    logic [16:0] e;
    e = model_byte(c, pos[c]);
    check($sformatf("ch%0d_p%0d_addr", c, pos[c]), send_addr[c*8 +: 8], e[16:9]);
    check($sformatf("ch%0d_p%0d_data", c, pos[c]), send_data[c*8 +: 8], e[8:1]);
    check($sformatf("ch%0d_p%0d_more", c, pos[c]), brust_vaild[c], e[0]);
    brust_ready[c] = 1'b1;
    if (!brust_vaild[c]) begin mst[c] = 2; dly[c] = $urandom_range(1, 3); end
    else dly[c] = $urandom_range(4, 7);
    pos[c]++;
    if (pos[c] == FR + 6) begin pos[c] = 0; frames_seen[c]++; end
  endtask

  // I2C master models: accept send_en, consume bytes with random spacing, release send_busy.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < CH; c++) begin
      brust_ready[c] = 1'b0;
      if (!rst_n) begin
        mst[c] = 0;
        send_busy[c] = 1'b0;
      end else begin
        if (send_en[c]) check($sformatf("ch%0d_send_en_when_idle", c), (mst[c] == 0), 1);
        case (mst[c])
          0: if (send_en[c]) begin mst[c] = 1; send_busy[c] = 1'b1; dly[c] = $urandom_range(4, 7); end
          1: if (dly[c] > 0) dly[c]--; else consume(c);
          default: if (dly[c] > 0) dly[c]--; else begin send_busy[c] = 1'b0; mst[c] = 0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        if (frame_done[c]) begin
          done_cnt[c]++;
          check($sformatf("ch%0d_done_after_last", c), (pos[c] == 0 && mst[c] == 0), 1);
          check($sformatf("ch%0d_done_idle", c), busy[c], 0);
        end
        if (pos[c] > 0) check($sformatf("ch%0d_busy_in_frame", c), busy[c], 1);
      end
    end
  end

  task automatic pulse_req(input logic [CH-1:0] m);
    refresh_req = m;
    @(posedge clk); #2;
    refresh_req = '0;
  endtask

  task automatic wait_frames(input int budget);
    int n = 0;
    bit ok;
    do begin
      @(posedge clk); #2;
      n++;
      ok = 1'b1;
      for (int c = 0; c < CH; c++)
        if (done_cnt[c] != exp_frames[c] || frames_seen[c] != exp_frames[c]) ok = 1'b0;
    end while (!ok && n < budget);
    repeat (40) @(posedge clk);
    #2;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("ch%0d_frame_done_count", c), done_cnt[c], exp_frames[c]);
      check($sformatf("ch%0d_frames_streamed", c), frames_seen[c], exp_frames[c]);
      check($sformatf("ch%0d_idle_after", c), busy[c], 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_send_en"}, send_en, 0);
    check({tag, "_send_addr"}, send_addr, 0);
    check({tag, "_send_data"}, send_data, 0);
    check({tag, "_brust_vaild"}, brust_vaild, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic clear_model();
    for (int c = 0; c < CH; c++) begin
      pos[c] = 0; frames_seen[c] = 0; done_cnt[c] = 0; exp_frames[c] = 0;
    end
  endtask

  initial begin
    int n, base;
    bit ok;
    logic [CH-1:0] r;
    for (int i = 0; i < CH*FR; i++) fb_mem[i] = 8'($urandom);
    clear_model();
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;

    // All channels requested together: grants rotate 0,1,2,3 and stop once every FIFO holds 2.
    refresh_req = '1;
    @(posedge clk); #2;
    refresh_req = '0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("rr_fb_addr_%0d", i), fb_addr, rr_exp[i]);
      @(posedge clk); #2;
    end
    for (int c = 0; c < CH; c++) exp_frames[c]++;
    wait_frames(3000);

    // Two requests during a frame merge into one extra frame.
    pulse_req(4'b0010);
    exp_frames[1] += 2;
    n = 0;
    while (pos[1] < 12 && n < 2000) begin @(posedge clk); #2; n++; end
    check("req_merge_reach_mid_frame", (pos[1] >= 12), 1);
    pulse_req(4'b0010);
    repeat (3) @(posedge clk);
    #2;
    pulse_req(4'b0010);
    wait_frames(4000);

    // Auto refresh for at least three frames, dropped while every channel is mid-frame.
    base = frames_seen[0];
    auto_refresh = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
      ok = (frames_seen[0] >= base + 3);
      for (int c = 0; c < CH; c++) if (pos[c] == 0) ok = 1'b0;
    end while (!ok && n < 10000);
    check("auto_three_frames", ok, 1);
    auto_refresh = 1'b0;
    for (int c = 0; c < CH; c++) exp_frames[c] = frames_seen[c] + 1;
    wait_frames(3000);

    for (int k = 0; k < 4; k++) begin
      r = CH'($urandom_range(1, 15));
      pulse_req(r);
      for (int c = 0; c < CH; c++) if (r[c]) exp_frames[c]++;
      wait_frames(3000);
    end

    // Asynchronous reset with channel 0 about to send data byte 37.
    pulse_req(4'b0001);
    n = 0;
    while (pos[0] != 6 + 37 && n < 3000) begin @(posedge clk); #2; n++; end
    check("rst_reach_byte37", pos[0], 6 + 37);
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    pulse_req(4'b0001);
    exp_frames[0] = 1;
    wait_frames(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
